// File: rtl/wisc_pipe_pkg.sv
// Shared pipeline definitions: opcode constants, the bubble encoding and
// the IF/ID entry record carried through the skid queue.
package wisc_pipe_pkg;

    localparam int WISC_DW = 16;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    localparam logic [WISC_DW-1:0] NOP_INSTR = {OP_NOP, 11'h000};

    typedef struct packed {
        logic [WISC_DW-1:0] instr;
        logic [WISC_DW-1:0] pc_inc;
    } ifid_entry_t;

    function automatic logic [4:0] opcode_of(input logic [WISC_DW-1:0] instr);
        return instr[15:11];
    endfunction

endpackage

// File: rtl/ifid_skid_fifo.sv
// Circular skid queue holding fetch beats that arrive while decode is held.
// Push and pop may coincide even when full; clear empties it in one cycle.
module ifid_skid_fifo
    import wisc_pipe_pkg::*;
#(
    parameter int SKID_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  ifid_entry_t push_data,
    output ifid_entry_t head_data,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    ifid_entry_t        mem_q [SKID_DEPTH];
    ifid_entry_t        mem_d [SKID_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)
                head_d = ptr_inc(head_q);
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = ptr_inc(tail_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SKID_DEPTH; i++)
                mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign full      = (count_q == CNT_W'(SKID_DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/ifid_stage_latch.sv
// IF/ID stage register with hold/squash handling and a skid queue for beats in flight.
// Define IFID_PERF_EN to add saturating hold/squash/bubble counters.
module ifid_stage_latch #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    SKID_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = wisc_pipe_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [DATA_WIDTH-1:0] fetch_instr,
    input  logic [DATA_WIDTH-1:0] fetch_pc_inc,
    input  logic                  hold,
    input  logic                  squash,
    input  logic                  imem_nop,
    output logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_inc_d,
    output logic                  valid_d,
    output logic [4:0]            opcode_d,
`ifdef IFID_PERF_EN
    output logic [15:0]           hold_cycles,
    output logic [15:0]           squash_count,
    output logic [15:0]           bubble_count,
`endif
    output logic                  halted
);

    import wisc_pipe_pkg::ifid_entry_t;
    import wisc_pipe_pkg::OP_HALT;

    logic [DATA_WIDTH-1:0] slot_instr_q, slot_instr_d;
    logic [DATA_WIDTH-1:0] slot_pc_q, slot_pc_d;
    logic                  slot_valid_q, slot_valid_d;
    logic                  halted_q, halted_d;

    ifid_entry_t beat_entry, head_entry;
    logic        beat, advance, load_nop;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fetch_ready = ~fifo_full & ~halted_q;
    assign beat        = fetch_valid & ~imem_nop & fetch_ready;
    assign advance     = ~squash & ~hold;

    assign beat_entry.instr  = fetch_instr;
    assign beat_entry.pc_inc = fetch_pc_inc;

    // Beats go through the queue whenever decode is held or older beats are still queued.
    assign fifo_push = beat & ~squash & (hold | ~fifo_empty);
    assign fifo_pop  = advance & ~fifo_empty;
    assign load_nop  = advance & fifo_empty & ~beat;

    ifid_skid_fifo #(.SKID_DEPTH(SKID_DEPTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (squash),
        .push_data (beat_entry),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        slot_valid_d = slot_valid_q;
        halted_d     = halted_q;
        if (squash) begin
            slot_instr_d = NOP_INSTR;
            slot_valid_d = 1'b0;
            halted_d     = 1'b0;
        end else if (!hold) begin
            if (!fifo_empty) begin
                slot_instr_d = head_entry.instr;
                slot_pc_d    = head_entry.pc_inc;
                slot_valid_d = 1'b1;
            end else if (beat) begin
                slot_instr_d = fetch_instr;
                slot_pc_d    = fetch_pc_inc;
                slot_valid_d = 1'b1;
            end else begin
                slot_instr_d = NOP_INSTR;
                slot_valid_d = 1'b0;
            end
            if (slot_valid_d && slot_instr_d[15:11] == OP_HALT)
                halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_instr_q <= NOP_INSTR;
            slot_pc_q    <= '0;
            slot_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
            slot_valid_q <= slot_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign instr_d  = slot_instr_q;
    assign pc_inc_d = slot_pc_q;
    assign valid_d  = slot_valid_q;
    assign opcode_d = slot_instr_q[15:11];
    assign halted   = halted_q;

`ifdef IFID_PERF_EN
    logic [15:0] hold_cycles_q, hold_cycles_d;
    logic [15:0] squash_count_q, squash_count_d;
    logic [15:0] bubble_count_q, bubble_count_d;

    always_comb begin
        hold_cycles_d  = hold_cycles_q;
        squash_count_d = squash_count_q;
        bubble_count_d = bubble_count_q;
        if (hold && !squash && hold_cycles_q != 16'hFFFF)
            hold_cycles_d = hold_cycles_q + 16'd1;
        if (squash && squash_count_q != 16'hFFFF)
            squash_count_d = squash_count_q + 16'd1;
        if (load_nop && bubble_count_q != 16'hFFFF)
            bubble_count_d = bubble_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cycles_q  <= '0;
            squash_count_q <= '0;
            bubble_count_q <= '0;
        end else begin
            hold_cycles_q  <= hold_cycles_d;
            squash_count_q <= squash_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign hold_cycles  = hold_cycles_q;
    assign squash_count = squash_count_q;
    assign bubble_count = bubble_count_q;
`else
    logic unused_load_nop;
    assign unused_load_nop = load_nop;
`endif

endmodule
